// File: rtl/apb_led_sequencer.sv
// apb_led_sequencer: APB-programmable LED pattern sequencer.
//
// A prescaler produces one step every DIV+1 cycles while CTRL.EN is set.
// On each step the LED register rotates, ping-pongs or blinks against
// PATTERN depending on CTRL.MODE. STATUS.WRAP flags the end of a pass and
// drives a level interrupt when CTRL.IE is set.
//
// Register map (paddr[3:2]):
//   0x0 CTRL    bit0 EN, bits2:1 MODE, bit3 IE
//   0x4 DIV     bits[DIV_W-1:0]
//   0x8 PATTERN bits[N_LED-1:0]
//   0xC STATUS  bit0 DIR (RO), bit1 WRAP (write 1 to clear)
//
// Ports:
//   pclk    - clock, rising edge
//   rstn    - asynchronous active-low reset
//   paddr   - APB address, bits 1:0 ignored
//   pwrite, psel, penable - APB control
//   pwdata  - APB write data
//   prdata  - registered read data, loaded in the APB setup phase
//   led     - registered LED drive
//   irq     - level interrupt, STATUS.WRAP & CTRL.IE

module apb_led_sequencer #(
    parameter int N_LED = 8,
    parameter int DIV_W = 24
) (
    input  logic             pclk,
    input  logic             rstn,
    input  logic [3:0]       paddr,
    input  logic             pwrite,
    input  logic             psel,
    input  logic             penable,
    input  logic [31:0]      pwdata,
    output logic [31:0]      prdata,
    output logic [N_LED-1:0] led,
    output logic             irq
);

    typedef enum logic [1:0] {
        MODE_ROL   = 2'd0,
        MODE_ROR   = 2'd1,
        MODE_PING  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_DIV    = 2'd1;
    localparam logic [1:0] A_PAT    = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    logic [3:0]       ctrl_q,   ctrl_d;
    logic [DIV_W-1:0] div_q,    div_d;
    logic [N_LED-1:0] pat_q,    pat_d;
    logic [N_LED-1:0] led_q,    led_d;
    logic [DIV_W-1:0] cnt_q,    cnt_d;
    logic [31:0]      prdata_q, prdata_d;
    logic             dir_q,    dir_d;
    logic             wrap_q,   wrap_d;

    logic       wr_en, rd_en, cnt_clr, tc, step, wrap_hit;
    logic [1:0] sel;
    mode_e      mode;
    logic       unused_bits;

    assign sel     = paddr[3:2];
    assign wr_en   = psel & penable & pwrite;
    assign rd_en   = psel & ~penable & ~pwrite;
    assign mode    = mode_e'(ctrl_q[2:1]);
    // Any write other than STATUS restarts the prescaler and cancels the
    // step that would otherwise fall in this cycle.
    assign cnt_clr = wr_en & (sel != A_STATUS);
    assign tc      = ctrl_q[0] & (cnt_q == div_q);
    assign step    = tc & ~cnt_clr;

    assign unused_bits = ^{paddr[1:0], pwdata};

    always_comb begin
        ctrl_d   = ctrl_q;
        div_d    = div_q;
        pat_d    = pat_q;
        led_d    = led_q;
        dir_d    = dir_q;
        wrap_d   = wrap_q;
        prdata_d = prdata_q;
        wrap_hit = 1'b0;

        cnt_d = (!ctrl_q[0] || cnt_clr || tc) ? '0 : cnt_q + DIV_W'(1);

        if (step) begin
            unique case (mode)
                MODE_ROL: begin
                    led_d    = {led_q[N_LED-2:0], led_q[N_LED-1]};
                    wrap_hit = led_q[N_LED-1];
                end
                MODE_ROR: begin
                    led_d    = {led_q[0], led_q[N_LED-1:1]};
                    wrap_hit = led_q[0];
                end
                MODE_PING: begin
                    if (!dir_q) begin
                        if (led_q[N_LED-1]) begin
                            dir_d    = 1'b1;
                            led_d    = led_q >> 1;
                            wrap_hit = 1'b1;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            dir_d    = 1'b0;
                            led_d    = led_q << 1;
                            wrap_hit = 1'b1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                MODE_BLINK: begin
                    led_d = led_q ^ pat_q;
                    // Post-step led equals PATTERN exactly when led was zero;
                    // a zero PATTERN never blinks, so it never wraps.
                    wrap_hit = (led_q == '0) && (pat_q != '0);
                end
            endcase
        end

        if (wr_en) begin
            case (sel)
                A_CTRL: ctrl_d = pwdata[3:0];
                A_DIV:  div_d  = pwdata[DIV_W-1:0];
                A_PAT: begin
                    pat_d = pwdata[N_LED-1:0];
                    led_d = pwdata[N_LED-1:0];
                    dir_d = 1'b0;
                end
                default: begin
                    if (pwdata[1]) wrap_d = 1'b0;
                end
            endcase
        end

        // A new wrap beats a coincident W1C.
        if (wrap_hit) wrap_d = 1'b1;

        if (rd_en) begin
            case (sel)
                A_CTRL:  prdata_d = 32'(ctrl_q);
                A_DIV:   prdata_d = 32'(div_q);
                A_PAT:   prdata_d = 32'(pat_q);
                default: prdata_d = 32'({wrap_q, dir_q});
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q   <= '0;
            div_q    <= '0;
            pat_q    <= '0;
            led_q    <= '0;
            cnt_q    <= '0;
            prdata_q <= '0;
            dir_q    <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            div_q    <= div_d;
            pat_q    <= pat_d;
            led_q    <= led_d;
            cnt_q    <= cnt_d;
            prdata_q <= prdata_d;
            dir_q    <= dir_d;
            wrap_q   <= wrap_d;
        end
    end

    assign prdata = prdata_q;
    assign led    = led_q;
    assign irq    = wrap_q & ctrl_q[3];

endmodule

// File: tb/tb_apb_led_sequencer.sv
module tb_apb_led_sequencer;

    logic        pclk    = 1'b0;
    logic        rstn    = 1'b0;
    logic [3:0]  paddr   = '0;
    logic        pwrite  = 1'b0;
    logic        psel    = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] pwdata  = '0;
    logic [31:0] prdata;
    logic [7:0]  led;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, plain integers.
    int m_ctrl = 0, m_div = 0, m_pat = 0, m_led = 0;
    int m_dir = 0, m_wrap = 0, m_cnt = 0, m_prd = 0;

    always #5 pclk = ~pclk;

    apb_led_sequencer #(.N_LED(8), .DIV_W(24)) dut (
        .pclk    (pclk),
        .rstn    (rstn),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .psel    (psel),
        .penable (penable),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .led     (led),
        .irq     (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_div = 0; m_pat = 0; m_led = 0;
        m_dir = 0; m_wrap = 0; m_cnt = 0; m_prd = 0;
    endtask

    // One clock: predict from the current bus inputs, clock, compare.
    task automatic cycle();
        int  sel, mode, nl, nd, nw, nc, np, nctrl, ndiv, npat;
        bit  wr, rd, clr, step, wc;
        sel   = int'(paddr[3:2]);
        wr    = psel && penable && pwrite;
        rd    = psel && !penable && !pwrite;
        clr   = wr && (sel != 3);
        step  = (m_ctrl % 2 == 1) && (m_cnt == m_div) && !clr;
        mode  = (m_ctrl / 2) % 4;
        nl = m_led; nd = m_dir; nw = m_wrap; np = m_prd;
        nctrl = m_ctrl; ndiv = m_div; npat = m_pat; wc = 0;
        if (step) begin
            case (mode)
                0: begin nl = (m_led * 2) % 256 + m_led / 128; wc = (m_led >= 128); end
                1: begin nl = m_led / 2 + (m_led % 2) * 128; wc = (m_led % 2 == 1); end
                2: begin
                    if (m_dir == 0) begin
                        if (m_led >= 128) begin nd = 1; nl = m_led / 2; wc = 1; end
                        else nl = (m_led * 2) % 256;
                    end else begin
                        if (m_led % 2 == 1) begin nd = 0; nl = (m_led * 2) % 256; wc = 1; end
                        else nl = m_led / 2;
                    end
                end
                default: begin nl = m_led ^ m_pat; wc = (nl == m_pat) && (m_pat != 0); end
            endcase
        end
        if (m_ctrl % 2 == 0 || clr || m_cnt == m_div) nc = 0;
        else nc = m_cnt + 1;
        if (rd) begin
            case (sel)
                0: np = m_ctrl;
                1: np = m_div;
                2: np = m_pat;
                default: np = m_wrap * 2 + m_dir;
            endcase
        end
        if (wr) begin
            case (sel)
                0: nctrl = int'(pwdata[3:0]);
                1: ndiv  = int'(pwdata[23:0]);
                2: begin npat = int'(pwdata[7:0]); nl = npat; nd = 0; end
                default: if (pwdata[1]) nw = 0;
            endcase
        end
        if (step && wc) nw = 1;
        @(posedge pclk);
        if (rstn) begin
            m_ctrl = nctrl; m_div = ndiv; m_pat = npat; m_led = nl;
            m_dir = nd; m_wrap = nw; m_cnt = nc; m_prd = np;
        end else begin
            model_reset();
        end
        #1;
        check("led", 32'(led), m_led);
        check("irq", 32'(irq), (m_wrap == 1 && (m_ctrl / 8) % 2 == 1) ? 1 : 0);
        check("prdata", prdata, m_prd);
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        cycle();
        penable = 1'b1;
        cycle();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] v);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        cycle();
        penable = 1'b1;
        cycle();
        v = prdata;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic count_until(input logic [7:0] exp, input int budget, output int n);
        n = 0;
        while (led !== exp && n < budget) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  exp30 [9];
        logic [31:0] d;
        int          n, op;
        exp30 = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

        // Reset state
        cycle();
        cycle();
        check("rst_led", 32'(led), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_prdata", prdata, 0);
        rstn = 1'b1;

        // Rotate-left, DIV=3
        apb_write(4'h4, 32'd3);
        apb_write(4'h8, 32'h01);
        apb_write(4'h0, 32'h1);
        check("rol_start", 32'(led), 32'h01);
        count_until(8'h02, 20, n);
        check("rol_first_step_cycles", n, 4);
        count_until(8'h04, 20, n);
        check("rol_second_step_cycles", n, 4);
        count_until(8'h01, 40, n);
        check("rol_wrap_cycles", n, 24);
        apb_read(4'hC, v);
        check("rol_status_wrap", v, 32'h2);

        // Ping-pong, DIV=0
        apb_write(4'h0, 32'h0);
        apb_write(4'h8, 32'h80);
        apb_write(4'h0, 32'h5);
        apb_write(4'h4, 32'h0);
        check("ping_start", 32'(led), 32'h80);
        for (int i = 0; i < 9; i++) begin
            cycle();
            check("ping_seq", 32'(led), 32'(exp30[i]));
        end

        // Blink, DIV=1
        apb_write(4'h0, 32'h0);
        apb_write(4'h4, 32'h1);
        apb_write(4'h8, 32'h0F);
        apb_write(4'hC, 32'h2);
        apb_write(4'h0, 32'h7);
        cycle();
        check("blink_hold", 32'(led), 32'h0F);
        cycle();
        check("blink_off", 32'(led), 32'h00);
        apb_read(4'hC, v);
        check("blink_status_nowrap", v, 32'h0);
        check("blink_on", 32'(led), 32'h0F);
        apb_read(4'hC, v);
        check("blink_status_wrap", v, 32'h2);
        check("blink_off2", 32'(led), 32'h00);

        // Interrupt and W1C priority
        apb_write(4'h0, 32'h0);
        apb_write(4'h8, 32'h01);
        apb_write(4'h4, 32'd100);
        apb_write(4'h0, 32'h9);
        check("irq_set", 32'(irq), 1);
        apb_write(4'hC, 32'h2);
        check("irq_cleared", 32'(irq), 0);
        apb_write(4'h0, 32'h0);
        apb_write(4'h8, 32'h40);
        apb_write(4'h4, 32'h0);
        apb_write(4'h0, 32'h9);
        apb_write(4'hC, 32'h2);
        check("wrap_beats_w1c", 32'(irq), 1);

        // PATTERN write coincident with a step
        apb_write(4'h0, 32'h1);
        apb_write(4'h4, 32'd2);
        cycle();
        apb_write(4'h8, 32'hA5);
        check("pat_wins_step", 32'(led), 32'hA5);
        count_until(8'h4B, 10, n);
        check("pat_cnt_cleared", n, 3);
        apb_read(4'h8, v);
        check("read_pattern", v, 32'hA5);
        apb_read(4'hC, v);
        check("read_status", v, 32'h2);

        // Asynchronous reset mid-run
        apb_write(4'h0, 32'hB);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check("arst_led", 32'(led), 0);
        check("arst_irq", 32'(irq), 0);
        check("arst_prdata", prdata, 0);
        repeat (3) cycle();
        rstn = 1'b1;
        repeat (20) cycle();
        check("post_rst_idle", 32'(led), 0);
        apb_write(4'h0, 32'h1);
        repeat (10) cycle();
        check("zero_led_stays", 32'(led), 0);
        apb_read(4'hC, v);
        check("zero_led_nowrap", v, 32'h0);

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(0, 9);
            d  = $urandom;
            case (op)
                0, 1: apb_write({2'd0, 2'($urandom_range(0, 3))}, d);
                2: begin
                    d[23:0] = 24'($urandom_range(0, 4));
                    apb_write({2'd1, 2'($urandom_range(0, 3))}, d);
                end
                3: begin
                    if ($urandom_range(0, 5) == 0) d[7:0] = 8'h00;
                    apb_write({2'd2, 2'($urandom_range(0, 3))}, d);
                end
                4: apb_write(4'hC, d);
                5, 6: apb_read(4'($urandom_range(0, 15)), v);
                default: repeat ($urandom_range(1, 12)) cycle();
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
